// File: rtl/controle_multiciclo_if.sv
// rtl/controle_multiciclo_if.sv - control bundle between the multicycle controller and its datapath
interface controle_multiciclo_if #(
  parameter int W_CONT = 16
);
  logic [2:0]        OPcode;
  logic              bit_menos_sig;
  logic              zero;
  logic              memPronto;
  logic              escreveIR;
  logic              escrevePC;
  logic [1:0]        selPC;
  logic              iouD;
  logic              leMemoria;
  logic              escreveMemoria;
  logic              imediato;
  logic [1:0]        operacaoULA;
  logic              escreveRegistrador;
  logic              dadoEscrito;
  logic              halt;
  logic [2:0]        estado;
  logic [W_CONT-1:0] instrucoes;

  modport master (
    input  OPcode, bit_menos_sig, zero, memPronto,
    output escreveIR, escrevePC, selPC, iouD, leMemoria, escreveMemoria,
           imediato, operacaoULA, escreveRegistrador, dadoEscrito, halt,
           estado, instrucoes
  );

  modport slave (
    output OPcode, bit_menos_sig, zero, memPronto,
    input  escreveIR, escrevePC, selPC, iouD, leMemoria, escreveMemoria,
           imediato, operacaoULA, escreveRegistrador, dadoEscrito, halt,
           estado, instrucoes
  );
endinterface

// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multicycle control FSM sharing one memory port, one ULA and the register bank
module controle_multiciclo #(
  parameter int LAT_MUL = 3,
  parameter int W_CONT  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  controle_multiciclo_if.master bus
);
  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    PARADO     = 3'd5
  } estado_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_BEQ  = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_J    = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  localparam logic [3:0]        MUL_CARGA = 4'(LAT_MUL - 1);
  localparam logic [W_CONT-1:0] UM        = W_CONT'(1);

  estado_t           state;
  logic [3:0]        cnt_mul;
  logic [W_CONT-1:0] cont;

  logic       ir_w, pc_w, iou, le, we, imm, wr, dado, hlt;
  logic [1:0] sel, ula;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= BUSCA;
      cnt_mul <= '0;
      cont    <= '0;
    end else begin
      case (state)
        BUSCA: begin
          if (bus.memPronto) state <= DECODIFICA;
        end
        DECODIFICA: begin
          if (bus.OPcode == OP_ADD && bus.bit_menos_sig) begin
            state <= PARADO;
          end else if (bus.OPcode == OP_NOP) begin
            state <= BUSCA;
            cont  <= cont + UM;
          end else begin
            state <= EXECUTA;
            if (bus.OPcode == OP_MUL) cnt_mul <= MUL_CARGA;
          end
        end
        EXECUTA: begin
          case (bus.OPcode)
            OP_MUL: begin
              if (cnt_mul == 4'd0) state <= ESCRITA;
              else                 cnt_mul <= cnt_mul - 4'd1;
            end
            OP_BEQ, OP_J: begin
              state <= BUSCA;
              cont  <= cont + UM;
            end
            OP_LW, OP_SW: state <= MEMORIA;
            default:      state <= ESCRITA;
          endcase
        end
        MEMORIA: begin
          if (bus.memPronto) begin
            if (bus.OPcode == OP_LW) begin
              state <= ESCRITA;
            end else begin
              state <= BUSCA;
              cont  <= cont + UM;
            end
          end
        end
        ESCRITA: begin
          state <= BUSCA;
          cont  <= cont + UM;
        end
        PARADO:  state <= PARADO;
        default: state <= BUSCA;
      endcase
    end
  end

  // Outputs decode from the state; the reset gate below forces them low during reset.
  always_comb begin
    ir_w = 1'b0;
    pc_w = 1'b0;
    sel  = 2'd0;
    iou  = 1'b0;
    le   = 1'b0;
    we   = 1'b0;
    imm  = 1'b0;
    ula  = 2'd0;
    wr   = 1'b0;
    dado = 1'b0;
    hlt  = 1'b0;
    case (state)
      BUSCA: begin
        le = 1'b1;
        if (bus.memPronto) begin
          ir_w = 1'b1;
          pc_w = 1'b1;
        end
      end
      EXECUTA, ESCRITA: begin
        case (bus.OPcode)
          OP_ADD:       ula = 2'd1;
          OP_ADDI: begin
            ula = 2'd1;
            imm = 1'b1;
          end
          OP_MUL:       ula = 2'd2;
          OP_BEQ:       ula = 2'd3;
          OP_LW, OP_SW: imm = 1'b1;
          default:      ula = 2'd1;
        endcase
        if (state == EXECUTA) begin
          if (bus.OPcode == OP_J) begin
            ula  = 2'd0;
            pc_w = 1'b1;
            sel  = 2'd2;
          end else if (bus.OPcode == OP_BEQ && bus.zero) begin
            pc_w = 1'b1;
            sel  = 2'd1;
          end
        end else begin
          wr   = 1'b1;
          dado = (bus.OPcode != OP_LW);
        end
      end
      MEMORIA: begin
        iou = 1'b1;
        imm = 1'b1;
        le  = (bus.OPcode == OP_LW);
        we  = (bus.OPcode == OP_SW);
      end
      PARADO:  hlt = 1'b1;
      default: ;
    endcase
  end

  assign bus.escreveIR          = reset_n & ir_w;
  assign bus.escrevePC          = reset_n & pc_w;
  assign bus.selPC              = reset_n ? sel : 2'd0;
  assign bus.iouD               = reset_n & iou;
  assign bus.leMemoria          = reset_n & le;
  assign bus.escreveMemoria     = reset_n & we;
  assign bus.imediato           = reset_n & imm;
  assign bus.operacaoULA        = reset_n ? ula : 2'd0;
  assign bus.escreveRegistrador = reset_n & wr;
  assign bus.dadoEscrito        = reset_n & dado;
  assign bus.halt               = reset_n & hlt;
  assign bus.estado             = state;
  assign bus.instrucoes         = cont;
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb/tb_controle_multiciclo.sv - self-checking bench for controle_multiciclo against a per-cycle expectation model
module tb_controle_multiciclo;
  localparam int LAT = 3;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   n_ret  = 0;

  always #5 clock = ~clock;

  controle_multiciclo_if #(.W_CONT(16)) b1 ();
  controle_multiciclo_if #(.W_CONT(2))  b2 ();

  controle_multiciclo #(.LAT_MUL(LAT), .W_CONT(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b1)
  );

  controle_multiciclo #(.LAT_MUL(LAT), .W_CONT(2)) dut_w2 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b2)
  );

  assign b2.OPcode        = b1.OPcode;
  assign b2.bit_menos_sig = b1.bit_menos_sig;
  assign b2.zero          = b1.zero;
  assign b2.memPronto     = b1.memPronto;

  wire [12:0] outs = {b1.escreveIR, b1.escrevePC, b1.selPC, b1.iouD, b1.leMemoria,
                      b1.escreveMemoria, b1.imediato, b1.operacaoULA,
                      b1.escreveRegistrador, b1.dadoEscrito, b1.halt};

  typedef struct packed {
    logic       mp;
    logic       z;
    logic [2:0] est;
    logic [12:0] outs;
  } rec_t;

  rec_t q[$];

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [12:0] o(input logic ir, input logic pc, input logic [1:0] sel,
                                    input logic iou, input logic le, input logic we,
                                    input logic imm, input logic [1:0] ula, input logic wr,
                                    input logic dado, input logic hlt);
    return {ir, pc, sel, iou, le, we, imm, ula, wr, dado, hlt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] est, input logic [12:0] ot, input logic mp, input logic z);
    rec_t r;
    r.mp   = mp;
    r.z    = z;
    r.est  = est;
    r.outs = ot;
    q.push_back(r);
  endtask

  task automatic push_fetch(input int wf);
    for (int i = 0; i < wf; i++) push(3'd0, o(0,0,2'd0,0,1,0,0,2'd0,0,0,0), 1'b0, rb());
    push(3'd0, o(1,1,2'd0,0,1,0,0,2'd0,0,0,0), 1'b1, rb());
    push(3'd1, 13'd0, rb(), rb());
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, built from the ISA rules.
  task automatic model_instr(input logic [2:0] op, input logic z, input int wf, input int wm);
    logic [1:0] ula;
    logic       imm;
    push_fetch(wf);
    if (op == 3'd7) begin
      n_ret++;
      return;
    end
    case (op)
      3'd0:    begin ula = 2'd1; imm = 1'b0; end
      3'd1:    begin ula = 2'd1; imm = 1'b1; end
      3'd2:    begin ula = 2'd3; imm = 1'b0; end
      3'd6:    begin ula = 2'd2; imm = 1'b0; end
      3'd3, 3'd4: begin ula = 2'd0; imm = 1'b1; end
      default: begin ula = 2'd0; imm = 1'b0; end
    endcase
    if (op == 3'd5) begin
      push(3'd2, o(0,1,2'd2,0,0,0,0,2'd0,0,0,0), rb(), rb());
      n_ret++;
      return;
    end
    if (op == 3'd2) begin
      push(3'd2, o(0,z,z ? 2'd1 : 2'd0,0,0,0,0,2'd3,0,0,0), rb(), z);
      n_ret++;
      return;
    end
    for (int i = 0; i < ((op == 3'd6) ? LAT : 1); i++)
      push(3'd2, o(0,0,2'd0,0,0,0,imm,ula,0,0,0), rb(), rb());
    if (op == 3'd3 || op == 3'd4) begin
      for (int i = 0; i <= wm; i++)
        push(3'd3, o(0,0,2'd0,1,op == 3'd3,op == 3'd4,1,2'd0,0,0,0), i == wm, rb());
      if (op == 3'd4) begin
        n_ret++;
        return;
      end
    end
    push(3'd4, o(0,0,2'd0,0,0,0,imm,ula,1,op != 3'd3,0), rb(), rb());
    n_ret++;
  endtask

  task automatic run_queue(input int n);
    int   lim;
    rec_t r;
    lim = (n < 0) ? q.size() : n;
    for (int k = 0; k < lim; k++) begin
      r = q.pop_front();
      @(negedge clock);
      b1.memPronto = r.mp;
      b1.zero      = r.z;
      #1;
      chk("estado", 32'(b1.estado), 32'(r.est));
      chk("outs", 32'(outs), 32'(r.outs));
      @(posedge clock);
    end
  endtask

  task automatic check_count();
    #1;
    chk("instrucoes", 32'(b1.instrucoes), 32'(n_ret % 65536));
    chk("estado_busca", 32'(b1.estado), 32'd0);
  endtask

  task automatic do_instr(input logic [2:0] op, input logic z, input int wf, input int wm);
    b1.OPcode        = op;
    b1.bit_menos_sig = (op == 3'd0) ? 1'b0 : rb();
    model_instr(op, z, wf, wm);
    run_queue(-1);
    check_count();
  endtask

  initial begin
    reset_n          = 1'b0;
    b1.OPcode        = 3'd0;
    b1.bit_menos_sig = 1'b0;
    b1.zero          = 1'b0;
    b1.memPronto     = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    b1.memPronto = 1'b1;
    #1;
    chk("reset_estado", 32'(b1.estado), 32'd0);
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_count", 32'(b1.instrucoes), 32'd0);
    b1.memPronto = 1'b0;
    reset_n      = 1'b1;

    do_instr(3'd0, 1'b0, 0, 0);
    do_instr(3'd3, 1'b0, 0, 3);
    do_instr(3'd2, 1'b1, 0, 0);
    do_instr(3'd2, 1'b0, 0, 0);
    do_instr(3'd6, 1'b0, 0, 0);
    do_instr(3'd4, 1'b0, 1, 2);
    do_instr(3'd7, 1'b0, 0, 0);

    for (int i = 0; i < 40; i++)
      do_instr(3'($urandom_range(0, 7)), rb(), $urandom_range(0, 3), $urandom_range(0, 3));

    // Halt: stays parked with memPronto toggling, count frozen.
    b1.OPcode        = 3'd0;
    b1.bit_menos_sig = 1'b1;
    push_fetch(0);
    for (int i = 0; i < 20; i++) push(3'd5, o(0,0,2'd0,0,0,0,0,2'd0,0,0,1), 1'(i), rb());
    run_queue(-1);
    #1;
    chk("halt_count", 32'(b1.instrucoes), 32'(n_ret % 65536));
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("halt_reset_outs", 32'(outs), 32'd0);
    @(posedge clock);
    #1;
    chk("halt_reset_estado", 32'(b1.estado), 32'd0);
    chk("halt_reset_count", 32'(b1.instrucoes), 32'd0);
    @(negedge clock);
    b1.memPronto = 1'b0;
    reset_n      = 1'b1;
    n_ret        = 0;

    // Reset in the middle of a pending store.
    b1.OPcode        = 3'd4;
    b1.bit_menos_sig = 1'b0;
    model_instr(3'd4, 1'b0, 0, 5);
    run_queue(4);
    q.delete();
    @(negedge clock);
    b1.memPronto = 1'b0;
    #1;
    chk("sw_pending_we", 32'(b1.escreveMemoria), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("sw_reset_we", 32'(b1.escreveMemoria), 32'd0);
    chk("sw_reset_outs", 32'(outs), 32'd0);
    chk("sw_reset_estado_hold", 32'(b1.estado), 32'd3);
    @(posedge clock);
    #1;
    chk("sw_reset_estado", 32'(b1.estado), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    n_ret   = 0;

    // Narrow counter wraps 3 -> 0.
    for (int i = 1; i <= 4; i++) begin
      do_instr(3'd5, 1'b0, 0, 0);
      chk("w2_count", 32'(b2.instrucoes), 32'(i % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
